parity_stream_pipe: RTL and testbench
=====================================

# parity_stream_pipe

Pipelined, multi-lane streaming parity generator. It is the parametrised successor to our combinational XOR reduction tree and is used on wide datapaths where a single-cycle reduction cannot close timing. The tree is registered every `LEVELS_PER_STAGE` levels. Per-lane parity accumulates across multi-beat packets. Each packet produces one result with even/odd mode selection, under a valid/ready handshake with full backpressure.

## Interface
Parameters:
- `LOG_WIDTH`, default 6: each lane is 2^LOG_WIDTH bits wide.
- `LANES`, default 4: number of independent parity lanes.
- `LEVELS_PER_STAGE`, default 2: XOR tree levels between pipeline registers. Legal range is 1..LOG_WIDTH.
- `BEAT_W`, default 8: width of the packet beat counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rst_n`  in  1  asynchronous active-low reset.
- Input side:
  - `in_valid`  in  1  input beat valid.
  - `in_ready`  out  1  input beat accepted when high together with `in_valid`.
  - `in_data`  in  LANES*2^LOG_WIDTH  lane k occupies bits [k*W +: W].
  - `in_last`  in  1  beat is the final beat of its packet.
  - `in_odd`  in  1  odd-parity mode. Sampled on the first beat of a packet only.
- Output side:
  - `out_valid`  out  1  packet result valid.
  - `out_ready`  in  1  downstream accepts the result.
  - `out_parity`  out  LANES  per-lane parity of the whole packet.
  - `out_beats`  out  BEAT_W  number of beats in the packet, saturating.

## Operation
- Tree stages:
  - S = ceil(LOG_WIDTH / LEVELS_PER_STAGE) registered tree stages per lane, each with a valid bit.
  - Each stage also carries the `last` and `odd` sideband bits alongside its valid bit.
  - The final stage may contain fewer than LEVELS_PER_STAGE levels.
- Accumulator stage, per lane:
  - State: `acc[LANES]`, `first` flag (reset 1), beat count `cnt`, and packet mode `mode`.
  - On a valid tree output `p`, if `first`: acc = p, cnt = 1, mode = odd sideband.
  - Otherwise: acc ^= p, and cnt = cnt+1, saturating at 2^BEAT_W-1.
  - If the beat carries `last`:
    - Load out_parity = (acc_next) ^ {LANES{mode_next}}, out_beats = cnt_next, out_valid = 1.
    - Set `first` = 1.
  - A single-beat packet (last on first beat) is legal. It produces parity = p ^ odd, beats = 1.
- Stall:
  - stall = out_valid & ~out_ready.
  - While stalled, every pipeline register, the accumulator and the outputs hold.
  - in_ready = ~stall, combinational from `out_ready`.
- Output handshake:
  - out_valid clears on an out_valid & out_ready cycle, unless a new result loads in that same cycle.
  - A same-cycle new result overwrites the outputs; no bubble.
- Invalid input beats:
  - in_valid low while not stalled inserts a bubble: the stage valid bit is 0.
  - The accumulator ignores bubbles.
  - A packet may be spread over non-consecutive cycles.
- Reset, including mid-packet:
  - All valid bits = 0, acc = 0, cnt = 0, first = 1, mode = 0.
  - Outputs reset to out_valid = 0, out_parity = 0, out_beats = 0.
  - Any partial packet is discarded.

## Timing
- Latency: a beat accepted at edge t reaches the accumulator at edge t+S. Its result, if `last`, is valid after edge t+S+1.
- Throughput: one beat per cycle when out_ready is held high.
- Back-to-back packets: the last beat of packet A followed directly by the first beat of packet B gives consecutive out_valid cycles.
- Backpressure is global. One stalled result freezes the whole pipe; no skid buffer.
- Defaults (LOG_WIDTH = 6, LPS = 2): S = 3, latency 4.
- With LPS = 4: S = 2, latency 3, and the final stage has 2 levels.

## Structure
- Package `parity_pkg` holds:
  - function `num_stages(log_w, lps)` returning ceil(log_w/lps);
  - function `levels_in_stage(idx, log_w, lps)`;
  - typedef of the sideband struct {valid, last, odd}.
- Sub-module `xor_reduce_stage`, parametrised by input width and level count:
  - combinational XOR-reduces pairs over its levels, then registers the result;
  - has a hold enable (= ~stall);
  - instantiated S × LANES times via generate.
- Top level holds the sideband pipeline, accumulator, counter and output register.

## Test plan
- Single-beat packet, defaults: lane 0 = 64'h1, other lanes 0, odd = 0, last = 1 -> after 4 cycles out_parity = 4'b0001, out_beats = 1.
- Three-beat packet in odd mode: lane 2 gets 64'h3, 64'h1, 64'h0 on consecutive beats, other lanes all-zero -> out_parity = 4'b1011 (lane 2 = 1^1 = 0, others = 1), out_beats = 3. The odd value presented on beats 2-3 must be ignored.
- Backpressure: out_ready held low for 5 cycles with a result pending -> in_ready low, outputs stable. Releasing out_ready resumes throughput with no lost or duplicated beats; scoreboard against a reference model over 1000 random packets.
- Saturation: BEAT_W = 2, 6-beat packet -> out_beats = 3.
- Reset mid-packet: assert rst_n low after beat 2 of a 4-beat packet -> out_valid = 0. The next packet's result excludes the old beats.
- Parameter sweep (LOG_WIDTH, LPS) ∈ {(3,1), (6,4), (6,6), (5,2)} -> latency = ceil(LOG_WIDTH/LPS)+1, and parity matches the reference model.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and elaboration-time helpers for the pipelined multi-lane parity generator.
package parity_pkg;

    typedef struct packed {
        logic valid;
        logic last;
        logic odd;
    } side_t;

    function automatic int num_stages(input int log_w, input int lps);
        return (log_w + lps - 1) / lps;
    endfunction

    // Every stage is full except possibly the last, which takes whatever levels remain.
    function automatic int levels_in_stage(input int idx, input int log_w, input int lps);
        int rem;
        rem = log_w - idx * lps;
        return (rem < lps) ? rem : lps;
    endfunction

endpackage

// File: rtl/xor_reduce_stage.sv
// One registered slice of the XOR reduction tree: folds IN_W bits down by 2^LEVELS.
module xor_reduce_stage #(
    parameter int IN_W   = 4,
    parameter int LEVELS = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [IN_W-1:0]             d,
    output logic [(IN_W >> LEVELS)-1:0] q
);
    localparam int OUT_W = IN_W >> LEVELS;
    localparam int GROUP = 1 << LEVELS;

    logic [OUT_W-1:0] red;

    // XOR over a contiguous group of 2^LEVELS bits is the same as LEVELS pairwise tree levels.
    always_comb begin
        // NOTE: default assignment first so no path through the block can infer a latch.
        red = '0;
        for (int j = 0; j < OUT_W; j++) begin
            red[j] = ^d[j*GROUP +: GROUP];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data register is reset as well, so a pre-reset partial beat never reappears.
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= red;
        end
    end

endmodule

// File: rtl/parity_stream_pipe.sv
// Pipelined multi-lane streaming parity: registered XOR trees, per-packet accumulation,
// even/odd mode, and one result register with global backpressure (no skid buffer).
module parity_stream_pipe
    import parity_pkg::*;
#(
    parameter int LOG_WIDTH        = 6,
    parameter int LANES            = 4,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int BEAT_W           = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*(1<<LOG_WIDTH)-1:0] in_data,
    input  logic                          in_last,
    input  logic                          in_odd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              out_parity,
    output logic [BEAT_W-1:0]             out_beats
);
    localparam int W = 1 << LOG_WIDTH;
    localparam int S = num_stages(LOG_WIDTH, LEVELS_PER_STAGE);

    logic en;
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    logic [LANES-1:0] p;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar s = 0; s < S; s++) begin : g_stage
            localparam int IN_W = 1 << (LOG_WIDTH - s * LEVELS_PER_STAGE);
            localparam int LV   = levels_in_stage(s, LOG_WIDTH, LEVELS_PER_STAGE);

            logic [IN_W-1:0]        d;
            logic [(IN_W >> LV)-1:0] q;

            if (s == 0) begin : g_first
                assign d = in_data[l*W +: W];
            end else begin : g_next
                assign d = g_stage[s-1].q;
            end

            xor_reduce_stage #(
                .IN_W  (IN_W),
                .LEVELS(LV)
            ) u_stage (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (en),
                .d    (d),
                .q    (q)
            );
        end
        assign p[l] = g_stage[S-1].q;
    end

    side_t side [S];
    side_t tail;
    assign tail = side[S-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < S; s++) side[s] <= '0;
        end else if (en) begin
            side[0] <= side_t'{valid: in_valid, last: in_last, odd: in_odd};
            for (int s = 1; s < S; s++) side[s] <= side[s-1];
        end
    end

    logic [LANES-1:0]  acc, acc_next;
    logic [BEAT_W-1:0] cnt, cnt_next;
    logic              first, mode, mode_next;

    always_comb begin
        acc_next  = first ? p : (acc ^ p);
        mode_next = first ? tail.odd : mode;
        if (first) begin
            cnt_next = BEAT_W'(1);
        end else if (cnt == '1) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + BEAT_W'(1);
        end
    end

    // The result register sits between accumulation and the output, so a beat accepted
    // at edge t is accumulated at t+S and its packet result is visible after t+S+1.
    logic              res_valid;
    logic [LANES-1:0]  res_parity;
    logic [BEAT_W-1:0] res_beats;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            first      <= 1'b1;
            mode       <= 1'b0;
            res_valid  <= 1'b0;
            res_parity <= '0;
            res_beats  <= '0;
        end else if (en) begin
            res_valid <= tail.valid & tail.last;
            if (tail.valid) begin
                acc   <= acc_next;
                cnt   <= cnt_next;
                mode  <= mode_next;
                first <= tail.last;
                if (tail.last) begin
                    res_parity <= acc_next ^ {LANES{mode_next}};
                    res_beats  <= cnt_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_parity <= '0;
            out_beats  <= '0;
        end else if (en) begin
            out_valid <= res_valid;
            if (res_valid) begin
                out_parity <= res_parity;
                out_beats  <= res_beats;
            end
        end
    end

endmodule

// File: tb/tb_parity_stream_pipe.sv
// Bench for parity_stream_pipe: six parameter configurations share one stimulus stream,
// each scored against a packet-level parity model, plus table vectors and directed corners.
module tb_parity_stream_pipe;

    localparam int NCFG = 6;

    function automatic int cfg_lw(input int g);
        case (g)
            2:       return 3;
            5:       return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int cfg_lps(input int g);
        case (g)
            2:       return 1;
            3:       return 4;
            4:       return 6;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_bw(input int g);
        return (g == 1) ? 2 : 8;
    endfunction

    function automatic int exp_lat(input int g);
        return (cfg_lw(g) + cfg_lps(g) - 1) / cfg_lps(g) + 1;
    endfunction

    function automatic logic [63:0] lane_mask(input int g);
        int w;
        w = 1 << cfg_lw(g);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [255:0] mk(input logic [63:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_last, in_odd, out_ready;
    logic [255:0] din;

    logic [NCFG-1:0] ov, ir;
    logic [3:0]      op [NCFG];
    logic [7:0]      ob [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int LW  = cfg_lw(g);
        localparam int LPS = cfg_lps(g);
        localparam int BW  = cfg_bw(g);
        localparam int W   = 1 << LW;

        logic [4*W-1:0] d;
        logic [3:0]     par;
        logic [BW-1:0]  beats;
        logic           vo, ri;

        for (genvar k = 0; k < 4; k++) begin : g_ln
            assign d[k*W +: W] = din[k*64 +: W];
        end

        parity_stream_pipe #(
            .LOG_WIDTH       (LW),
            .LANES           (4),
            .LEVELS_PER_STAGE(LPS),
            .BEAT_W          (BW)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ri),
            .in_data   (d),
            .in_last   (in_last),
            .in_odd    (in_odd),
            .out_valid (vo),
            .out_ready (out_ready),
            .out_parity(par),
            .out_beats (beats)
        );

        assign ov[g] = vo;
        assign ir[g] = ri;
        assign op[g] = par;
        assign ob[g] = 8'(beats);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: XOR of every accepted beat's masked lane, odd taken from the first beat.
    logic [3:0] m_par   [NCFG];
    logic       m_odd   [NCFG];
    int         m_n     [NCFG];
    logic [3:0] e_par   [NCFG][16];
    int         e_beats [NCFG][16];
    int         e_wr    [NCFG];
    int         e_rd    [NCFG];
    logic       acc0;

    task automatic sb_sample();
        for (int g = 0; g < NCFG; g++) begin
            if (!rst_n) begin
                m_n[g]  = 0;
                e_wr[g] = 0;
                e_rd[g] = 0;
            end else begin
                if (ov[g] && out_ready) begin
                    check($sformatf("sb_avail[%0d]", g), 32'(e_wr[g] != e_rd[g]), 32'd1);
                    if (e_wr[g] != e_rd[g]) begin
                        check($sformatf("sb_parity[%0d]", g), 32'(op[g]), 32'(e_par[g][e_rd[g] % 16]));
                        check($sformatf("sb_beats[%0d]", g), 32'(ob[g]), 32'(e_beats[g][e_rd[g] % 16]));
                        e_rd[g]++;
                    end
                end
                if (in_valid && ir[g]) begin
                    if (m_n[g] == 0) begin
                        m_par[g] = '0;
                        m_odd[g] = in_odd;
                    end
                    for (int k = 0; k < 4; k++) begin
                        m_par[g][k] = m_par[g][k] ^ (^(din[k*64 +: 64] & lane_mask(g)));
                    end
                    m_n[g]++;
                    if (in_last) begin
                        e_par[g][e_wr[g] % 16]   = m_par[g] ^ {4{m_odd[g]}};
                        e_beats[g][e_wr[g] % 16] = (m_n[g] < (1 << cfg_bw(g)) - 1) ? m_n[g]
                                                                                 : (1 << cfg_bw(g)) - 1;
                        e_wr[g]++;
                        m_n[g] = 0;
                    end
                end
            end
        end
        acc0 = rst_n && in_valid && ir[0];
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [255:0] d, input logic odd, input logic last);
        in_valid = 1'b1;
        din      = d;
        in_odd   = odd;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input int g, input string name);
        for (int i = 0; i < 16 && !ov[g]; i++) tick();
        check({name, "_seen"}, 32'(ov[g]), 32'd1);
    endtask

    typedef struct {
        logic [255:0] data;
        logic         odd;
        logic [3:0]   par;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{data: mk(64'h1, 64'h0, 64'h0, 64'h0), odd: 1'b0, par: 4'b0001};
        vecs[1] = '{data: mk(64'h0, 64'h0, 64'h0, 64'h0), odd: 1'b1, par: 4'b1111};
        vecs[2] = '{data: mk(64'h0, 64'h3, 64'h0, 64'h8000_0000_0000_0000), odd: 1'b0, par: 4'b1000};
        vecs[3] = '{data: mk(64'hF0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0), odd: 1'b1, par: 4'b1011};
        vecs[4] = '{data: mk(64'h8000_0000_0000_0001, 64'h100, 64'h7, 64'hFFFF), odd: 1'b0, par: 4'b0110};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_odd    = 1'b0;
        out_ready = 1'b1;
        din       = '0;
        acc0      = 1'b0;
        repeat (3) tick();

        check("rst_out_valid", 32'(ov), 32'd0);
        check("rst_out_parity", 32'(op[0]), 32'd0);
        check("rst_out_beats", 32'(ob[0]), 32'd0);
        check("rst_in_ready", 32'(ir), 32'h3F);
        rst_n = 1'b1;
        tick();

        // Single-beat packets: parity, beat count and per-configuration latency.
        for (int v = 0; v < 5; v++) begin
            int first_lat [NCFG];
            for (int g = 0; g < NCFG; g++) first_lat[g] = -1;
            drive(vecs[v].data, vecs[v].odd, 1'b1);
            for (int lat = 0; lat < 10; lat++) begin
                for (int g = 0; g < NCFG; g++) begin
                    if (first_lat[g] < 0 && ov[g]) begin
                        first_lat[g] = lat;
                        if (g == 0) begin
                            check($sformatf("vec%0d_parity", v), 32'(op[0]), 32'(vecs[v].par));
                            check($sformatf("vec%0d_beats", v), 32'(ob[0]), 32'd1);
                        end
                    end
                end
                tick();
            end
            for (int g = 0; g < NCFG; g++) begin
                check($sformatf("vec%0d_latency[%0d]", v, g), 32'(first_lat[g]), 32'(exp_lat(g)));
            end
        end

        // Three-beat odd packet; odd on later beats must be ignored.
        drive(mk(64'h0, 64'h0, 64'h3, 64'h0), 1'b1, 1'b0);
        drive(mk(64'h0, 64'h0, 64'h1, 64'h0), 1'b0, 1'b0);
        drive(mk(64'h0, 64'h0, 64'h0, 64'h0), 1'b0, 1'b1);
        wait_valid(0, "three_beat");
        check("three_beat_parity", 32'(op[0]), 32'b1011);
        check("three_beat_beats", 32'(ob[0]), 32'd3);
        repeat (6) tick();

        // Back-to-back packets give consecutive results.
        drive(mk(64'h1, 64'h0, 64'h0, 64'h0), 1'b0, 1'b1);
        drive(mk(64'h0, 64'h1, 64'h0, 64'h0), 1'b0, 1'b1);
        wait_valid(0, "b2b_a");
        check("b2b_a_parity", 32'(op[0]), 32'b0001);
        tick();
        check("b2b_b_valid", 32'(ov[0]), 32'd1);
        check("b2b_b_parity", 32'(op[0]), 32'b0010);
        repeat (6) tick();

        // Backpressure: result held, in_ready low, for five cycles.
        drive(mk(64'h0, 64'h1, 64'h0, 64'h0), 1'b0, 1'b1);
        wait_valid(0, "bp");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_valid_%0d", i), 32'(ov[0]), 32'd1);
            check($sformatf("bp_parity_%0d", i), 32'(op[0]), 32'b0010);
            check($sformatf("bp_beats_%0d", i), 32'(ob[0]), 32'd1);
            check($sformatf("bp_in_ready_%0d", i), 32'(ir[0]), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(ov[0]), 32'd0);
        check("bp_release_in_ready", 32'(ir[0]), 32'd1);
        repeat (6) tick();

        // Saturation: six beats into the BEAT_W=2 instance.
        for (int b = 0; b < 6; b++) begin
            drive((b == 5) ? mk(64'h0, 64'h0, 64'h0, 64'h1) : mk(64'h1, 64'h0, 64'h0, 64'h0),
                  1'b0, (b == 5));
        end
        wait_valid(1, "sat");
        check("sat_beats_bw2", 32'(ob[1]), 32'd3);
        check("sat_parity_bw2", 32'(op[1]), 32'b1001);
        check("sat_beats_bw8", 32'(ob[0]), 32'd6);
        repeat (6) tick();

        // Reset in the middle of a packet discards the partial packet.
        drive(mk(64'h1, 64'h0, 64'h0, 64'h0), 1'b1, 1'b0);
        drive(mk(64'h1, 64'h1, 64'h0, 64'h0), 1'b1, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", 32'(ov), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(mk(64'h0, 64'h0, 64'h0, 64'h1), 1'b0, 1'b1);
        wait_valid(0, "midrst");
        check("midrst_parity", 32'(op[0]), 32'b1000);
        check("midrst_beats", 32'(ob[0]), 32'd1);
        repeat (6) tick();

        // Random packets with bubbles and random backpressure, scored by the model.
        for (int pkt = 0; pkt < 1000; pkt++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                int waited;
                while ($urandom_range(0, 3) == 0) begin
                    in_valid  = 1'b0;
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                in_valid = 1'b1;
                for (int i = 0; i < 8; i++) din[i*32 +: 32] = $urandom;
                in_odd  = 1'($urandom_range(0, 1));
                in_last = (b == len - 1);
                waited  = 0;
                do begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                    waited++;
                end while (!acc0 && waited < 64);
                if (!acc0) check("rand_accept_timeout", 32'(acc0), 32'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
        end

        out_ready = 1'b1;
        repeat (20) tick();
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("drain_pending[%0d]", g), 32'(e_wr[g] - e_rd[g]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
